fetch_prefetch_unit: RTL and testbench

//  Parametrised successor to the single-shot fetch stage. Streams

---
 rtl/fetch_pkg.sv | 38 +++
 rtl/fetch_if.sv | 30 +++
 rtl/fetch_bundle_fifo.sv | 51 +++++
 rtl/fetch_prefetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching fetch stage: FSM encoding,
// default widths and immediate-field bit manipulation.
package fetch_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 32;
  localparam int DEFAULT_IMM_COUNT   = 4;
  localparam int DEFAULT_IMM_LSB     = 20;
  localparam int DEFAULT_QUEUE_DEPTH = 2;

  localparam int MAX_IMM_COUNT = 8;
  localparam int IMM_IDX_W     = 3;

  typedef enum logic [1:0] {
    S_WAIT_MEM = 2'd0,
    S_IDLE     = 2'd1,
    S_OPCODE   = 2'd2,
    S_IMM      = 2'd3
  } fetch_state_e;

  // One-hot of the lowest set bit (zero in, zero out).
  function automatic logic [MAX_IMM_COUNT-1:0] lowest_set(input logic [MAX_IMM_COUNT-1:0] bits);
    return bits & (~bits + {{(MAX_IMM_COUNT-1){1'b0}}, 1'b1});
  endfunction

  // Opcode field has immediate0 at its MSB; flip it so bit k means immediate k.
  function automatic logic [MAX_IMM_COUNT-1:0] reverse_field(input logic [MAX_IMM_COUNT-1:0] f,
                                                              input int n);
    logic [MAX_IMM_COUNT-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_IMM_COUNT; k++) begin
      if (k < n) r[IMM_IDX_W'(k)] = f[IMM_IDX_W'(n - 1 - k)];
      else       r[IMM_IDX_W'(k)] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of memory-port, redirect and decode-side signals of the fetch stage.
interface fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IMM_COUNT  = 4
);
  logic                            enable;
  logic [DATA_WIDTH-1:0]           data;
  logic [ADDR_WIDTH-1:0]           address;
  logic                            load;
  logic                            memoryReady;
  logic [ADDR_WIDTH-1:0]           addressIn;
  logic                            latch;
  logic                            outValid;
  logic                            outAccept;
  logic [DATA_WIDTH-1:0]           instruction;
  logic [IMM_COUNT*DATA_WIDTH-1:0] immediates;
  logic [IMM_COUNT-1:0]            immMask;
  logic [ADDR_WIDTH-1:0]           bundlePc;

  modport master (
    input  enable, data, memoryReady, addressIn, latch, outAccept,
    output address, load, outValid, instruction, immediates, immMask, bundlePc
  );

  modport slave (
    output enable, data, memoryReady, addressIn, latch, outAccept,
    input  address, load, outValid, instruction, immediates, immMask, bundlePc
  );
endinterface

// File: rtl/fetch_bundle_fifo.sv
// Small FIFO of assembled instruction bundles; flush empties it in one cycle.
module fetch_bundle_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage; contents are meaningless outside the occupied range.
  always_ff @(posedge clock) begin
    if (push_ok && !reset && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: streams opcode + immediate bundles from memory into
// a bundle queue ahead of decode, with flush-and-restart on redirect.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int IMM_COUNT   = DEFAULT_IMM_COUNT,
  parameter int IMM_LSB     = DEFAULT_IMM_LSB,
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input logic     clock,
  input logic     reset,
  fetch_if.master bus
);
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int CNT_W1  = CNT_W + 1;
  localparam int IMMS_W  = IMM_COUNT * DATA_WIDTH;
  localparam int ENTRY_W = ADDR_WIDTH + IMM_COUNT + IMMS_W + DATA_WIDTH;

  fetch_state_e          state;
  fetch_state_e          next_state;
  fetch_state_e          fsm_next;
  fetch_state_e          after_push;
  logic                  fetch_load;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] cur_pc;
  logic [DATA_WIDTH-1:0] cur_opcode;
  logic [IMMS_W-1:0]     cur_imms;
  logic [IMM_COUNT-1:0]  cur_mask;
  logic [IMM_COUNT-1:0]  pending;

  logic                  accept;
  logic [IMM_COUNT-1:0]  field_idx;
  logic [IMM_COUNT-1:0]  imm_sel;
  logic                  last_imm;
  logic [IMMS_W-1:0]     merged_imms;
  logic                  fsm_push;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [DATA_WIDTH-1:0] push_instr;
  logic [IMM_COUNT-1:0]  push_mask;
  logic [IMMS_W-1:0]     push_imms;
  logic [CNT_W-1:0]      count;
  logic [CNT_W1-1:0]     count_after;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    head;

  // Masks are kept in immediate-index order: bit k set means immediate k present.
  assign accept    = fetch_load && bus.memoryReady;
  assign field_idx = IMM_COUNT'(reverse_field(MAX_IMM_COUNT'(bus.data[IMM_LSB +: IMM_COUNT]), IMM_COUNT));
  assign imm_sel   = IMM_COUNT'(lowest_set(MAX_IMM_COUNT'(pending)));
  assign last_imm  = ((pending & ~imm_sel) == '0);

  for (genvar k = 0; k < IMM_COUNT; k++) begin : g_merge
    assign merged_imms[k*DATA_WIDTH +: DATA_WIDTH] =
      imm_sel[k] ? bus.data : cur_imms[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Redirect beats both the consumer pop and any push on the same edge.
  assign pop         = bus.outAccept && !fifo_empty && !bus.latch;
  assign push        = fsm_push && !bus.latch;
  assign count_after = {1'b0, count} + CNT_W1'(1) - CNT_W1'(pop);
  assign after_push  = (bus.enable && (count_after < CNT_W1'(QUEUE_DEPTH))) ? S_OPCODE : S_IDLE;
  assign next_state  = bus.latch ? (bus.memoryReady ? S_IDLE : S_WAIT_MEM) : fsm_next;

  // Next-state and bundle-push decode.
  always_comb begin
    fsm_next   = state;
    fsm_push   = 1'b0;
    push_pc    = cur_pc;
    push_instr = cur_opcode;
    push_mask  = cur_mask;
    push_imms  = merged_imms;
    case (state)
      S_WAIT_MEM: begin
        if (bus.memoryReady) fsm_next = S_IDLE;
        else                 fsm_next = S_WAIT_MEM;
      end
      S_IDLE: begin
        if (bus.enable && (count < CNT_W'(QUEUE_DEPTH))) fsm_next = S_OPCODE;
        else                                              fsm_next = S_IDLE;
      end
      S_OPCODE: begin
        if (accept && (field_idx == '0)) begin
          fsm_push   = 1'b1;
          push_pc    = fetch_addr;
          push_instr = bus.data;
          push_mask  = '0;
          push_imms  = '0;
          fsm_next   = after_push;
        end else if (accept) begin
          fsm_next = S_IMM;
        end else begin
          fsm_next = S_OPCODE;
        end
      end
      S_IMM: begin
        if (accept && last_imm) begin
          fsm_push = 1'b1;
          fsm_next = after_push;
        end else begin
          fsm_next = S_IMM;
        end
      end
      default: fsm_next = S_WAIT_MEM;
    endcase
  end

  // State, address counter and partial-bundle registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_WAIT_MEM;
      fetch_load <= 1'b0;
      fetch_addr <= '0;
      cur_pc     <= '0;
      cur_opcode <= '0;
      cur_imms   <= '0;
      cur_mask   <= '0;
      pending    <= '0;
    end else if (bus.latch) begin
      state      <= next_state;
      fetch_load <= 1'b0;
      fetch_addr <= bus.addressIn;
      pending    <= '0;
    end else begin
      state      <= next_state;
      fetch_load <= (next_state == S_OPCODE) || (next_state == S_IMM);
      if (accept) fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
      if (accept && (state == S_OPCODE)) begin
        cur_pc     <= fetch_addr;
        cur_opcode <= bus.data;
        cur_mask   <= field_idx;
        cur_imms   <= '0;
        pending    <= field_idx;
      end else if (accept && (state == S_IMM)) begin
        cur_imms <= merged_imms;
        pending  <= pending & ~imm_sel;
      end
    end
  end

  fetch_bundle_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.latch),
    .push      (push),
    .push_data ({push_pc, push_mask, push_imms, push_instr}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  assign bus.address  = fetch_addr;
  assign bus.load     = fetch_load;
  assign bus.outValid = !fifo_empty;
  assign {bus.bundlePc, bus.immMask, bus.immediates, bus.instruction} = head;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a word-addressed memory model.
module tb_fetch_prefetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem [0:511];
  int          total;
  int          passed;
  int          failed;

  fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .IMM_COUNT(4)) bus ();

  fetch_prefetch_unit #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .IMM_COUNT   (4),
    .IMM_LSB     (20),
    .QUEUE_DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Address 0xFFFFFFFF aliases to slot 511 of the model.
  assign bus.data = mem[bus.address[8:0]];

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_00A0;
    mem[1]   = 32'h0000_00A1;
    mem[2]   = 32'h0000_00A2;
    mem[8]   = 32'h00A0_0008;
    mem[9]   = 32'hAAAA_0009;
    mem[10]  = 32'hBBBB_000A;
    mem[11]  = 32'h0000_000B;
    mem[32]  = 32'h00F0_0020;
    mem[33]  = 32'h1111_1111;
    mem[34]  = 32'h2222_2222;
    mem[35]  = 32'h3333_3333;
    mem[36]  = 32'h4444_4444;
    mem[37]  = 32'h0080_0025;
    mem[38]  = 32'h5555_0026;
    mem[256] = 32'h0000_0100;
    mem[511] = 32'h0010_01FF;

    reset = 1'b1;
    bus.enable = 1'b0; bus.latch = 1'b0; bus.outAccept = 1'b0;
    bus.memoryReady = 1'b0; bus.addressIn = 32'h0;
    step(); step();
    chk("rst_address", bus.address, 32'h0);
    chk("rst_load", bus.load, 1'b0);
    chk("rst_outvalid", bus.outValid, 1'b0);

    // Fill the queue from address 0
    reset = 1'b0; bus.memoryReady = 1'b1; bus.enable = 1'b1;
    step();
    chk("t1_idle_load", bus.load, 1'b0);
    step();
    chk("t1_opc_load", bus.load, 1'b1);
    chk("t1_addr0", bus.address, 32'h0);
    chk("t1_not_valid_yet", bus.outValid, 1'b0);
    step();
    chk("t1_valid", bus.outValid, 1'b1);
    chk("t1_pc", bus.bundlePc, 32'h0);
    chk("t1_mask", bus.immMask, 4'b0000);
    chk("t1_instr", bus.instruction, 32'h0000_00A0);
    chk("t1_addr1", bus.address, 32'h1);
    step();
    chk("t1_full_load", bus.load, 1'b0);
    chk("t1_addr2", bus.address, 32'h2);
    step(); step();
    chk("t3_hold_load", bus.load, 1'b0);
    chk("t3_hold_addr", bus.address, 32'h2);
    chk("t3_hold_pc", bus.bundlePc, 32'h0);

    // One pop frees one slot, exactly one new bundle is fetched
    bus.outAccept = 1'b1; step(); bus.outAccept = 1'b0;
    chk("t3_pop_pc", bus.bundlePc, 32'h1);
    chk("t3_pop_instr", bus.instruction, 32'h0000_00A1);
    chk("t3_pop_load", bus.load, 1'b0);
    step();
    chk("t3_refill_load", bus.load, 1'b1);
    chk("t3_refill_addr", bus.address, 32'h2);
    step();
    chk("t3_refull_load", bus.load, 1'b0);
    chk("t3_refull_addr", bus.address, 32'h3);
    step();
    chk("t3_no_overflow", bus.load, 1'b0);

    // Redirect to 8: bundle with immediates 0 and 2
    bus.latch = 1'b1; bus.addressIn = 32'h8; bus.outAccept = 1'b1;
    step();
    bus.latch = 1'b0; bus.outAccept = 1'b0;
    chk("t2_flush_valid", bus.outValid, 1'b0);
    chk("t2_flush_addr", bus.address, 32'h8);
    chk("t2_flush_load", bus.load, 1'b0);
    step(); step(); step(); step();
    chk("t2_valid", bus.outValid, 1'b1);
    chk("t2_instr", bus.instruction, 32'h00A0_0008);
    chk("t2_imms", bus.immediates, 128'h0000_0000_BBBB_000A_0000_0000_AAAA_0009);
    chk("t2_mask", bus.immMask, 4'b0101);
    chk("t2_pc", bus.bundlePc, 32'h8);
    chk("t2_addr", bus.address, 32'hB);
    chk("t2_b2b_load", bus.load, 1'b1);
    step();
    bus.enable = 1'b0; bus.outAccept = 1'b1;
    step();
    bus.outAccept = 1'b0;
    chk("t2_next_pc", bus.bundlePc, 32'hB);
    chk("t2_next_instr", bus.instruction, 32'h0000_000B);
    chk("t2_next_mask", bus.immMask, 4'b0000);

    // Four immediates with memoryReady toggling
    bus.latch = 1'b1; bus.addressIn = 32'h20; bus.enable = 1'b1;
    step();
    bus.latch = 1'b0;
    step();
    chk("t5_load", bus.load, 1'b1);
    chk("t5_addr_start", bus.address, 32'h20);
    for (int i = 0; i < 10; i++) begin
      bus.memoryReady = 1'(i % 2);
      step();
      chk("t5_addr_step", bus.address, 32'(32'h20 + (i + 1) / 2));
    end
    bus.memoryReady = 1'b0;
    chk("t5_valid", bus.outValid, 1'b1);
    chk("t5_imms", bus.immediates, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    chk("t5_mask", bus.immMask, 4'b1111);
    chk("t5_pc", bus.bundlePc, 32'h20);
    chk("t5_instr", bus.instruction, 32'h00F0_0020);

    // Redirect mid-immediate with a queued bundle and a pop request
    bus.memoryReady = 1'b1;
    step();
    chk("t4_in_imm_addr", bus.address, 32'h26);
    bus.latch = 1'b1; bus.addressIn = 32'h100; bus.outAccept = 1'b1;
    step();
    bus.latch = 1'b0; bus.outAccept = 1'b0;
    chk("t4_flush_valid", bus.outValid, 1'b0);
    chk("t4_flush_addr", bus.address, 32'h100);
    chk("t4_flush_load", bus.load, 1'b0);
    step();
    bus.enable = 1'b0;
    step();
    chk("t4_valid", bus.outValid, 1'b1);
    chk("t4_pc", bus.bundlePc, 32'h100);
    chk("t4_instr", bus.instruction, 32'h0000_0100);
    chk("t4_noen_load", bus.load, 1'b0);
    chk("t4_addr", bus.address, 32'h101);

    // Address wrap: immediate3 fetched from address 0
    bus.latch = 1'b1; bus.addressIn = 32'hFFFF_FFFF; bus.enable = 1'b1;
    step();
    bus.latch = 1'b0;
    step();
    chk("t6_top_addr", bus.address, 32'hFFFF_FFFF);
    step();
    chk("t6_wrap_addr", bus.address, 32'h0);
    chk("t6_wrap_load", bus.load, 1'b1);
    step();
    chk("t6_valid", bus.outValid, 1'b1);
    chk("t6_pc", bus.bundlePc, 32'hFFFF_FFFF);
    chk("t6_mask", bus.immMask, 4'b1000);
    chk("t6_imms", bus.immediates, 128'h0000_00A0_0000_0000_0000_0000_0000_0000);
    chk("t6_instr", bus.instruction, 32'h0010_01FF);
    chk("t6_addr", bus.address, 32'h1);

    // Reset (with a simultaneous latch) in the middle of a bundle
    bus.latch = 1'b1; bus.addressIn = 32'h8;
    step();
    bus.latch = 1'b0;
    step(); step();
    chk("t6_mid_addr", bus.address, 32'h9);
    reset = 1'b1; bus.latch = 1'b1; bus.addressIn = 32'h55;
    step();
    reset = 1'b0; bus.latch = 1'b0; bus.memoryReady = 1'b0;
    chk("t6_rst_addr", bus.address, 32'h0);
    chk("t6_rst_load", bus.load, 1'b0);
    chk("t6_rst_valid", bus.outValid, 1'b0);
    step();
    chk("t6_wait_load", bus.load, 1'b0);
    chk("t6_wait_valid", bus.outValid, 1'b0);
    bus.memoryReady = 1'b1;
    step(); step();
    chk("t6_restart_load", bus.load, 1'b1);
    chk("t6_restart_addr", bus.address, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
